// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port controller.
package regfile_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = $clog2(NREG);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_MUL
    } grant_t;

    typedef enum logic {
        PRIO_ALU,
        PRIO_MUL
    } prio_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    // One-hot decode of a register address into a write-enable vector.
    function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] addr);
        onehot_dec = NREG'(1) << addr;
    endfunction

endpackage

// File: rtl/wr_scoreboard.sv
// Busy scoreboard: one bit per register marking an outstanding multiplier write.
module wr_scoreboard
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear first so a same-address set in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port between the ALU and multiplier
// result paths with round-robin arbitration and a WAW busy scoreboard.
module regfile_wr_arbiter
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_addr,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mul_valid,
    input  logic [AW-1:0]   mul_addr,
    input  logic [DW-1:0]   mul_data,
    output logic            mul_ready,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_ready,
    output logic [NREG-1:0] wr_en,
    output logic [DW-1:0]   wr_data,
    output logic [NREG-1:0] busy
);

    grant_t          gnt_c;
    prio_t           prio_q;
    prio_t           prio_d;
    logic [NREG-1:0] wr_en_q;
    logic [NREG-1:0] wr_en_d;
    logic [DW-1:0]   wr_data_q;
    logic [DW-1:0]   wr_data_d;
    logic [NREG-1:0] busy_c;
    logic            alu_elig_c;
    logic            mul_elig_c;
    logic            rsv_set_c;
    wr_req_t         alu_req_c;
    wr_req_t         mul_req_c;
    wr_req_t         sel_req_c;

    always_comb begin
        alu_req_c.addr = alu_addr;
        alu_req_c.data = alu_data;
        mul_req_c.addr = mul_addr;
        mul_req_c.data = mul_data;
    end

    // Eligibility and 2-way round-robin; only an actual grant moves prio.
    always_comb begin
        gnt_c      = GNT_NONE;
        prio_d     = prio_q;
        sel_req_c  = alu_req_c;
        alu_elig_c = !reset && alu_valid && !busy_c[alu_addr];
        mul_elig_c = !reset && mul_valid;
        if (alu_elig_c && mul_elig_c) begin
            gnt_c = (prio_q == PRIO_MUL) ? GNT_MUL : GNT_ALU;
        end else if (alu_elig_c) begin
            gnt_c = GNT_ALU;
        end else if (mul_elig_c) begin
            gnt_c = GNT_MUL;
        end
        case (gnt_c)
            GNT_ALU: begin
                prio_d = PRIO_MUL;
            end
            GNT_MUL: begin
                prio_d    = PRIO_ALU;
                sel_req_c = mul_req_c;
            end
            default: begin
            end
        endcase
    end

    // Write-port stage: enables pulse for one cycle, data holds when idle.
    always_comb begin
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        if (gnt_c != GNT_NONE) begin
            wr_en_d   = onehot_dec(sel_req_c.addr);
            wr_data_d = sel_req_c.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q    <= PRIO_ALU;
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign alu_ready = (gnt_c == GNT_ALU);
    assign mul_ready = (gnt_c == GNT_MUL);
    assign rsv_ready = !reset && !busy_c[rsv_addr];
    assign rsv_set_c = rsv_valid && rsv_ready;

    wr_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (rsv_set_c),
        .set_addr (rsv_addr),
        .clr_en   (mul_ready),
        .clr_addr (mul_addr),
        .busy     (busy_c)
    );

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_c;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed + randomized bench for regfile_wr_arbiter against a behavioural model.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            alu_ready;
    logic            mul_valid;
    logic [AW-1:0]   mul_addr;
    logic [DW-1:0]   mul_data;
    logic            mul_ready;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_ready;
    logic [NREG-1:0] wr_en;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pending-register set, whose turn it is, and the expected port.
    bit              m_busy [NREG];
    bit              m_mul_turn;
    logic [NREG-1:0] m_wr_en;
    logic [DW-1:0]   m_wr_data;
    int              m_gnt;       // 0 none, 1 alu, 2 mul
    bit              m_rsv_acc;

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mul_valid (mul_valid),
        .mul_addr  (mul_addr),
        .mul_data  (mul_data),
        .mul_ready (mul_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_busy_vec();
        logic [NREG-1:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic predict();
        bit a_ok, m_ok;
        a_ok = !reset && alu_valid && !m_busy[alu_addr];
        m_ok = !reset && mul_valid;
        if (a_ok && m_ok) m_gnt = m_mul_turn ? 2 : 1;
        else if (a_ok)    m_gnt = 1;
        else if (m_ok)    m_gnt = 2;
        else              m_gnt = 0;
        m_rsv_acc = !reset && rsv_valid && !m_busy[rsv_addr];
    endtask

    task automatic settle();
        @(negedge clk);
        predict();
        chk("model_alu_ready", 32'(alu_ready), 32'(m_gnt == 1));
        chk("model_mul_ready", 32'(mul_ready), 32'(m_gnt == 2));
        chk("model_rsv_ready", 32'(rsv_ready), 32'(!reset && !m_busy[rsv_addr]));
        chk("model_wr_en", 32'(wr_en), 32'(m_wr_en));
        chk("model_wr_data", wr_data, m_wr_data);
        chk("model_busy", 32'(busy), 32'(model_busy_vec()));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            m_mul_turn = 1'b0;
            m_wr_en    = '0;
            m_wr_data  = '0;
        end else begin
            m_wr_en = '0;
            if (m_gnt == 1) begin
                m_wr_en[alu_addr] = 1'b1;
                m_wr_data  = alu_data;
                m_mul_turn = 1'b1;
            end else if (m_gnt == 2) begin
                m_wr_en[mul_addr] = 1'b1;
                m_wr_data  = mul_data;
                m_mul_turn = 1'b0;
                m_busy[mul_addr] = 1'b0;
            end
            if (m_rsv_acc) m_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [AW-1:0] prev_addr;

        // Reset held with both requesters active.
        reset = 1'b1; rsv_valid = 1'b0; rsv_addr = '0;
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 32'h1111_1111;
        mul_valid = 1'b1; mul_addr = 3'd5; mul_data = 32'h2222_2222;
        predict();
        tick();
        repeat (3) begin
            settle();
            chk("rst_alu_ready", 32'(alu_ready), 32'd0);
            chk("rst_mul_ready", 32'(mul_ready), 32'd0);
            chk("rst_rsv_ready", 32'(rsv_ready), 32'd0);
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_wr_data", wr_data, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            tick();
        end

        // Contention straight out of reset.
        reset = 1'b0;
        settle();
        chk("cont_alu_first", 32'(alu_ready), 32'd1);
        chk("cont_mul_waits", 32'(mul_ready), 32'd0);
        tick();
        settle();
        chk("cont_mul_second", 32'(mul_ready), 32'd1);
        chk("cont_wr_en_alu", 32'(wr_en), 32'h04);
        chk("cont_wr_data_alu", wr_data, 32'h1111_1111);
        tick();
        alu_valid = 1'b0; mul_valid = 1'b0;
        settle();
        chk("cont_wr_en_mul", 32'(wr_en), 32'h20);
        chk("cont_wr_data_mul", wr_data, 32'h2222_2222);
        tick();

        // Hazard hold on r3.
        rsv_valid = 1'b1; rsv_addr = 3'd3;
        settle();
        chk("haz_rsv_ready", 32'(rsv_ready), 32'd1);
        tick();
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 32'hAAAA_0000;
        repeat (2) begin
            settle();
            chk("haz_alu_blocked", 32'(alu_ready), 32'd0);
            chk("haz_busy3", 32'(busy[3]), 32'd1);
            tick();
        end
        mul_valid = 1'b1; mul_addr = 3'd3; mul_data = 32'h0000_BBBB;
        settle();
        chk("haz_mul_ready", 32'(mul_ready), 32'd1);
        chk("haz_alu_still_blocked", 32'(alu_ready), 32'd0);
        tick();
        mul_valid = 1'b0;
        settle();
        chk("haz_wr_en_mul", 32'(wr_en), 32'h08);
        chk("haz_wr_data_mul", wr_data, 32'h0000_BBBB);
        chk("haz_alu_released", 32'(alu_ready), 32'd1);
        chk("haz_busy3_clear", 32'(busy[3]), 32'd0);
        tick();
        alu_valid = 1'b0;
        settle();
        chk("haz_wr_en_alu", 32'(wr_en), 32'h08);
        chk("haz_final_r3", wr_data, 32'hAAAA_0000);
        tick();

        // Same-cycle set and clear of r6.
        mul_valid = 1'b1; mul_addr = 3'd6; mul_data = 32'h6666_6666;
        rsv_valid = 1'b1; rsv_addr = 3'd6;
        settle();
        chk("sc_mul_ready", 32'(mul_ready), 32'd1);
        chk("sc_rsv_ready", 32'(rsv_ready), 32'd1);
        tick();
        mul_valid = 1'b0; rsv_valid = 1'b0;
        settle();
        chk("sc_busy6", 32'(busy[6]), 32'd1);
        chk("sc_wr_en", 32'(wr_en), 32'h40);
        chk("sc_wr_data", wr_data, 32'h6666_6666);
        tick();
        mul_valid = 1'b1; mul_data = 32'h6060_6060;
        settle();
        tick();
        mul_valid = 1'b0;

        // Mid-stream reset with busy = 0x81 and a grant in flight.
        rsv_valid = 1'b1; rsv_addr = 3'd0;
        settle(); tick();
        rsv_addr = 3'd7;
        settle(); tick();
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 32'h1234_5678;
        settle();
        chk("mr_busy_81", 32'(busy), 32'h81);
        chk("mr_alu_grant", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        reset = 1'b1;
        settle();
        chk("mr_pending_wr_en", 32'(wr_en), 32'h02);
        tick();
        settle();
        chk("mr_wr_en_cleared", 32'(wr_en), 32'd0);
        chk("mr_busy_cleared", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 32'h4444_4444;
        mul_valid = 1'b1; mul_addr = 3'd5; mul_data = 32'h5555_5555;
        settle();
        chk("mr_alu_wins", 32'(alu_ready), 32'd1);
        chk("mr_mul_waits", 32'(mul_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        settle(); tick();
        mul_valid = 1'b0;

        // 16 back-to-back multiplier writes.
        prev_addr = '0;
        for (int i = 0; i < 16; i++) begin
            mul_valid = 1'b1; mul_addr = AW'(i * 3); mul_data = $urandom;
            settle();
            chk("stream_mul_ready", 32'(mul_ready), 32'd1);
            if (i > 0) chk("stream_wr_en", 32'(wr_en), 32'(onehot_dec(prev_addr)));
            prev_addr = mul_addr;
            tick();
        end
        mul_valid = 1'b0;
        settle();
        chk("stream_last_wr_en", 32'(wr_en), 32'(onehot_dec(prev_addr)));
        tick();

        // Randomized traffic; requesters hold until accepted.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(63) == 0);
            if (!alu_valid || m_gnt == 1) begin
                alu_valid = ($urandom_range(2) != 0);
                alu_addr  = AW'($urandom_range(NREG - 1));
                alu_data  = $urandom;
            end
            if (!mul_valid || m_gnt == 2) begin
                mul_valid = ($urandom_range(2) == 0);
                mul_addr  = AW'($urandom_range(NREG - 1));
                mul_data  = $urandom;
            end
            if (!rsv_valid || m_rsv_acc) begin
                rsv_valid = ($urandom_range(3) == 0);
                rsv_addr  = AW'($urandom_range(NREG - 1));
            end
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
